// File: rtl/hls_deadlock_multi_monitor_if.sv
// hls_deadlock_multi_monitor_if: stall-flag inputs, clear, and monitor status outputs.
interface hls_deadlock_multi_monitor_if #(
  parameter int N_AXIS = 4,
  parameter int N_INST = 2,
  parameter int CNT_W  = 5,
  parameter int SRC_W  = 3
);
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_INST-1:0] inst_block_sigs;
  logic              clear;
  logic              block;
  logic              deadlock;
  logic [SRC_W-1:0]  dl_src;
  logic [CNT_W-1:0]  blk_cnt;
  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  block, deadlock, dl_src, blk_cnt
  );
  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output block, deadlock, dl_src, blk_cnt
  );
endinterface

// File: rtl/hls_deadlock_multi_monitor.sv
// hls_deadlock_multi_monitor: persistence-filtered sticky deadlock detector over
// N_AXIS stream stalls and N_INST instance idle/block pairs.
module hls_deadlock_multi_monitor #(
  parameter int N_AXIS = 4,
  parameter int N_INST = 2,
  parameter int THRESH = 16,
  parameter int CNT_W  = 5,
  parameter int SRC_W  = 3
) (
  input logic clock,
  input logic reset,
  hls_deadlock_multi_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, LATCHED} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] src_q, src_d, src_now;
  logic block_q, axis_any, inst_stall, seq_blk, hit, set;
  always_comb begin
    axis_any   = |bus.axis_block_sigs;
    inst_stall = (&(bus.inst_idle_sigs | bus.inst_block_sigs)) & (|bus.inst_block_sigs);
    seq_blk    = axis_any | inst_stall;
    // descending scan leaves the lowest stalled stream index
    src_now = SRC_W'(N_AXIS);
    for (int i = N_AXIS - 1; i >= 0; i--)
      if (bus.axis_block_sigs[i]) src_now = SRC_W'(i);
    hit     = seq_blk && cnt_q == CNT_W'(THRESH - 1);
    state_d = bus.clear ? IDLE : state_q == LATCHED ? LATCHED : !seq_blk ? IDLE : hit ? LATCHED : COUNT;
    set     = state_d == LATCHED && state_q != LATCHED;
    src_d   = bus.clear ? '0 : set ? src_now : src_q;
    cnt_d   = (bus.clear || !seq_blk) ? '0 : cnt_q == CNT_W'(THRESH) ? cnt_q : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      block_q <= seq_blk;
    end
  end
  assign bus.block    = block_q;
  assign bus.deadlock = state_q == LATCHED;
  assign bus.dl_src   = src_q;
  assign bus.blk_cnt  = cnt_q;
endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// tb_hls_deadlock_multi_monitor: directed checks of the default build and a THRESH=1 build.
module tb_hls_deadlock_multi_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  hls_deadlock_multi_monitor_if #(.N_AXIS(4), .N_INST(2), .CNT_W(5), .SRC_W(3)) bus ();
  hls_deadlock_multi_monitor_if #(.N_AXIS(4), .N_INST(2), .CNT_W(5), .SRC_W(3)) bus1 ();

  hls_deadlock_multi_monitor #(.N_AXIS(4), .N_INST(2), .THRESH(16), .CNT_W(5), .SRC_W(3)) dut (
    .clock(clk), .reset(rst), .bus(bus.slave));
  hls_deadlock_multi_monitor #(.N_AXIS(4), .N_INST(2), .THRESH(1), .CNT_W(5), .SRC_W(3)) dut1 (
    .clock(clk), .reset(rst), .bus(bus1.slave));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({bus.block, bus.deadlock, bus.dl_src, bus.blk_cnt} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got blk=%b dl=%b src=%0d cnt=%0d want all 0", bus.block, bus.deadlock, bus.dl_src, bus.blk_cnt);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      checks++;
      if (bus.block !== 1'b0 || bus.deadlock !== 1'b0 || bus.blk_cnt !== 5'd0 || bus1.deadlock !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d got blk=%b dl=%b cnt=%0d dl1=%b want 0 0 0 0", c, bus.block, bus.deadlock, bus.blk_cnt, bus1.deadlock);
      end
    end
  endtask

  task automatic test_axis_hold();
    bus.axis_block_sigs = 4'b0100;
    tick(1);
    checks++;
    if (bus.block !== 1'b1 || bus.blk_cnt !== 5'd1 || bus.deadlock !== 1'b0) begin
      errors++;
      $display("FAIL axis_first got blk=%b cnt=%0d dl=%b want 1 1 0", bus.block, bus.blk_cnt, bus.deadlock);
    end
    tick(14);
    checks++;
    if (bus.blk_cnt !== 5'd15 || bus.deadlock !== 1'b0) begin
      errors++;
      $display("FAIL axis_c15 got cnt=%0d dl=%b want 15 0", bus.blk_cnt, bus.deadlock);
    end
    tick(1);
    checks++;
    if (bus.deadlock !== 1'b1 || bus.dl_src !== 3'd2 || bus.blk_cnt !== 5'd16) begin
      errors++;
      $display("FAIL axis_set got dl=%b src=%0d cnt=%0d want 1 2 16", bus.deadlock, bus.dl_src, bus.blk_cnt);
    end
    tick(3);
    checks++;
    if (bus.blk_cnt !== 5'd16 || bus.deadlock !== 1'b1) begin
      errors++;
      $display("FAIL axis_saturate got cnt=%0d dl=%b want 16 1", bus.blk_cnt, bus.deadlock);
    end
    bus.axis_block_sigs = 4'b0000;
    tick(1);
    checks++;
    if (bus.block !== 1'b0 || bus.deadlock !== 1'b1 || bus.blk_cnt !== 5'd0 || bus.dl_src !== 3'd2) begin
      errors++;
      $display("FAIL axis_drop got blk=%b dl=%b cnt=%0d src=%0d want 0 1 0 2", bus.block, bus.deadlock, bus.blk_cnt, bus.dl_src);
    end
    pulse_clear();
    checks++;
    if (bus.deadlock !== 1'b0 || bus.dl_src !== 3'd0) begin
      errors++;
      $display("FAIL axis_cleared got dl=%b src=%0d want 0 0", bus.deadlock, bus.dl_src);
    end
  endtask

  task automatic test_interrupt();
    bus.axis_block_sigs = 4'b0001;
    tick(15);
    bus.axis_block_sigs = 4'b0000;
    tick(1);
    checks++;
    if (bus.blk_cnt !== 5'd0 || bus.deadlock !== 1'b0) begin
      errors++;
      $display("FAIL gap_restart got cnt=%0d dl=%b want 0 0", bus.blk_cnt, bus.deadlock);
    end
    bus.axis_block_sigs = 4'b0001;
    tick(15);
    checks++;
    if (bus.deadlock !== 1'b0 || bus.blk_cnt !== 5'd15) begin
      errors++;
      $display("FAIL gap_early got dl=%b cnt=%0d want 0 15", bus.deadlock, bus.blk_cnt);
    end
    tick(1);
    checks++;
    if (bus.deadlock !== 1'b1 || bus.dl_src !== 3'd0) begin
      errors++;
      $display("FAIL gap_set got dl=%b src=%0d want 1 0", bus.deadlock, bus.dl_src);
    end
    bus.axis_block_sigs = 4'b0000;
    pulse_clear();
  endtask

  task automatic test_inst();
    bus.inst_idle_sigs  = 2'b01;
    bus.inst_block_sigs = 2'b10;
    tick(15);
    checks++;
    if (bus.deadlock !== 1'b0 || bus.block !== 1'b1) begin
      errors++;
      $display("FAIL inst_early got dl=%b blk=%b want 0 1", bus.deadlock, bus.block);
    end
    tick(1);
    checks++;
    if (bus.deadlock !== 1'b1 || bus.dl_src !== 3'd4) begin
      errors++;
      $display("FAIL inst_set got dl=%b src=%0d want 1 4", bus.deadlock, bus.dl_src);
    end
    bus.inst_block_sigs = 2'b00;
    pulse_clear();
    bus.inst_idle_sigs = 2'b11;
    tick(20);
    checks++;
    if (bus.deadlock !== 1'b0 || bus.block !== 1'b0 || bus.blk_cnt !== 5'd0) begin
      errors++;
      $display("FAIL inst_all_idle got dl=%b blk=%b cnt=%0d want 0 0 0", bus.deadlock, bus.block, bus.blk_cnt);
    end
    bus.inst_idle_sigs  = 2'b00;
    bus.inst_block_sigs = 2'b10;
    tick(2);
    checks++;
    if (bus.block !== 1'b0 || bus.blk_cnt !== 5'd0) begin
      errors++;
      $display("FAIL inst_one_busy got blk=%b cnt=%0d want 0 0", bus.block, bus.blk_cnt);
    end
    bus.inst_block_sigs = 2'b00;
  endtask

  task automatic test_clear();
    bus.axis_block_sigs = 4'b1000;
    tick(17);
    checks++;
    if (bus.deadlock !== 1'b1 || bus.dl_src !== 3'd3) begin
      errors++;
      $display("FAIL clr_latched got dl=%b src=%0d want 1 3", bus.deadlock, bus.dl_src);
    end
    pulse_clear();
    checks++;
    if (bus.deadlock !== 1'b0 || bus.dl_src !== 3'd0 || bus.blk_cnt !== 5'd0) begin
      errors++;
      $display("FAIL clr_pulse got dl=%b src=%0d cnt=%0d want 0 0 0", bus.deadlock, bus.dl_src, bus.blk_cnt);
    end
    tick(15);
    checks++;
    if (bus.deadlock !== 1'b0) begin
      errors++;
      $display("FAIL clr_early got dl=%b want 0", bus.deadlock);
    end
    tick(1);
    checks++;
    if (bus.deadlock !== 1'b1 || bus.dl_src !== 3'd3) begin
      errors++;
      $display("FAIL clr_reassert got dl=%b src=%0d want 1 3", bus.deadlock, bus.dl_src);
    end
    pulse_clear();
    tick(15);
    pulse_clear();
    checks++;
    if (bus.deadlock !== 1'b0 || bus.dl_src !== 3'd0 || bus.blk_cnt !== 5'd0) begin
      errors++;
      $display("FAIL clr_on_set got dl=%b src=%0d cnt=%0d want 0 0 0", bus.deadlock, bus.dl_src, bus.blk_cnt);
    end
    bus.axis_block_sigs = 4'b0000;
    tick(2);
  endtask

  task automatic test_async_reset();
    bus.axis_block_sigs = 4'b0010;
    tick(9);
    checks++;
    if (bus.blk_cnt !== 5'd9) begin
      errors++;
      $display("FAIL arst_pre got cnt=%0d want 9", bus.blk_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.block, bus.deadlock, bus.dl_src, bus.blk_cnt} !== 10'd0) begin
      errors++;
      $display("FAIL arst_mid got blk=%b dl=%b src=%0d cnt=%0d want all 0", bus.block, bus.deadlock, bus.dl_src, bus.blk_cnt);
    end
    #1 rst = 1'b0;
    bus.axis_block_sigs = 4'b0000;
    tick(2);
  endtask

  task automatic test_thresh1();
    bus1.axis_block_sigs = 4'b0001;
    tick(1);
    checks++;
    if (bus1.deadlock !== 1'b1 || bus1.dl_src !== 3'd0 || bus1.block !== 1'b1 || bus1.blk_cnt !== 5'd1) begin
      errors++;
      $display("FAIL t1_set got dl=%b src=%0d blk=%b cnt=%0d want 1 0 1 1", bus1.deadlock, bus1.dl_src, bus1.block, bus1.blk_cnt);
    end
    bus1.axis_block_sigs = 4'b0000;
    bus1.clear = 1'b1;
    tick(1);
    bus1.clear = 1'b0;
    bus1.inst_idle_sigs  = 2'b10;
    bus1.inst_block_sigs = 2'b01;
    tick(1);
    checks++;
    if (bus1.deadlock !== 1'b1 || bus1.dl_src !== 3'd4) begin
      errors++;
      $display("FAIL t1_inst got dl=%b src=%0d want 1 4", bus1.deadlock, bus1.dl_src);
    end
  endtask

  initial begin
    bus.axis_block_sigs  = '0; bus.inst_idle_sigs  = '0; bus.inst_block_sigs  = '0; bus.clear  = 1'b0;
    bus1.axis_block_sigs = '0; bus1.inst_idle_sigs = '0; bus1.inst_block_sigs = '0; bus1.clear = 1'b0;
    test_reset();
    test_axis_hold();
    test_interrupt();
    test_inst();
    test_clear();
    test_async_reset();
    test_thresh1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hls_deadlock_multi_monitor.md
Name: hls_deadlock_multi_monitor

Overview:
- Parametrised successor to the single-channel HLS deadlock monitor. Watches N_AXIS AXI-Stream block flags and N_INST sub-instance idle/block pairs.
- Provides a 1-cycle-latency instantaneous `block` output, plus a persistence-filtered, sticky `deadlock` flag. The flag carries the channel that triggered it.
- Sits beside the top HLS instance. Its outputs feed the debug status register and the host interrupt line.

Parameters:
- N_AXIS, 4, number of AXI-Stream block inputs (>=1)
- N_INST, 2, number of sub-instances monitored (>=1)
- THRESH, 16, consecutive blocked cycles needed to declare deadlock (>=1)
- CNT_W, 5, persistence counter width; must satisfy 2^CNT_W > THRESH
- SRC_W, 3, source-index width; must satisfy 2^SRC_W > N_AXIS

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- axis_block_sigs  in  N_AXIS  per-stream blocked flag (bit i = stream i stalled)
- inst_idle_sigs  in  N_INST  per-instance idle flag
- inst_block_sigs  in  N_INST  per-instance blocked flag
- clear  in  1  synchronous clear of sticky state, single-cycle pulse
- block  out  1  registered instantaneous block indication
- deadlock  out  1  sticky deadlock flag
- dl_src  out  SRC_W  trigger source latched at deadlock set
- blk_cnt  out  CNT_W  current persistence count, saturating

Behaviour:
- Reset is asynchronous and active-high. Clock is `clock`, reset is `reset`.
- Reset values: block=0, deadlock=0, dl_src=0, blk_cnt=0, FSM=IDLE.
- Combinational terms:
  - axis_any = OR of axis_block_sigs.
  - inst_stall = 1 when every instance i has (inst_idle_sigs[i] | inst_block_sigs[i]) AND at least one inst_block_sigs bit is set. An all-idle design is not a stall.
  - seq_blk = axis_any | inst_stall.
- block: registered copy of seq_blk, exactly 1 cycle latency. Unaffected by clear and by FSM state.
- blk_cnt:
  - When seq_blk=1, increments each cycle, saturating at THRESH.
  - When seq_blk=0, returns to 0 the next cycle.
  - clear forces it to 0.
- FSM states:
  - IDLE: blk_cnt==0. On seq_blk=1, go to COUNT.
  - COUNT: on seq_blk=0, go to IDLE. When seq_blk=1 and blk_cnt==THRESH-1, go to LATCHED and set deadlock=1 in the same edge.
  - LATCHED: deadlock stays 1 regardless of inputs. blk_cnt keeps tracking (saturating or dropping to 0). On clear, go to IDLE.
- THRESH=1: IDLE goes directly to LATCHED on the first seq_blk=1 cycle. deadlock rises 1 cycle after seq_blk.
- Generic timing: deadlock rises on the edge that ends the THRESH-th consecutive seq_blk=1 cycle.
- dl_src is captured on the same edge deadlock sets:
  - If axis_any=1, dl_src = lowest set index of axis_block_sigs.
  - Otherwise (instance-only stall), dl_src = N_AXIS.
  - dl_src holds until clear, which zeroes it.
- clear priority:
  - clear is honoured in every state and has priority over set in the same cycle: deadlock stays 0, dl_src=0, blk_cnt=0, FSM goes to IDLE.
  - If seq_blk is still 1 after clear, counting restarts from 0 on the next cycle.
- Interrupted run: a single seq_blk=0 cycle in COUNT fully restarts the count. There is no hysteresis.
- Reset mid-count or in LATCHED returns everything to reset values immediately, asynchronously.
- The block does not check parameter legality. An illegal CNT_W or SRC_W is a configuration error.

Test Plan:
- Reset, then inputs all 0 for 50 cycles: block=0, deadlock=0, blk_cnt=0 throughout.
- THRESH=16, axis_block_sigs=4'b0100 held:
  - block=1 from cycle 1.
  - deadlock=1 at cycle 16; dl_src=2; blk_cnt saturates at 16.
  - Drop input: block=0 next cycle, deadlock remains 1.
- axis_block_sigs=4'b0001 for 15 cycles, 0 for 1 cycle, then 4'b0001 again: no deadlock until 16 cycles after the restart.
- inst_idle_sigs=2'b01, inst_block_sigs=2'b10, axis=0 held: deadlock at cycle 16 with dl_src=4. Both idle and none blocked: never deadlock.
- In LATCHED with seq_blk held, pulse clear:
  - deadlock=0 and dl_src=0 next cycle.
  - deadlock re-asserts 16 cycles later.
  - clear on the exact set cycle: deadlock stays 0.
- Assert reset asynchronously mid-count (blk_cnt=9): all outputs 0 before the next clock edge. THRESH=1 build: deadlock 1 cycle after first seq_blk.
